sram_access_controller: RTL and testbench
=========================================

Name: sram_access_controller

Overview:
- Multi-cycle controller between the MEM stage and the 16-bit off-chip SRAM.
- Turns each 32-bit load/store into two sequenced 16-bit SRAM accesses, low half first, then high half, with configurable wait states per access.
- Drives `ready` low while a transaction is in flight; the pipeline uses `~ready` as its global freeze.

Parameters:
- MEM_BASE, 1024, byte address mapped to SRAM word 0.
- WAIT_CYCLES, 1, extra cycles each half-access is held (each phase lasts WAIT_CYCLES+1 cycles).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  load request from MEM stage.
- wr_en  in  1  store request from MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (Rm value).
- read_data  out  32  registered load result.
- ready  out  1  high = no transaction pending; low = freeze pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM halfword address.
- SRAM_WE_N  out  1  write strobe, active low.
- SRAM_OE_N  out  1  output enable, active low.
- SRAM_CE_N  out  1  chip enable, tied 0.
- SRAM_UB_N  out  1  upper byte enable, tied 0.
- SRAM_LB_N  out  1  lower byte enable, tied 0.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, wait counter=0, read_data=0.
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, SRAM_DQ hi-Z.
  - ready follows the IDLE rule below.
- Reset mid-transaction aborts it immediately; no partial write completes after reset.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational.
  - On a request at the clk edge: latch op (write if wr_en, else read), word index, write_data; go to LOW; counter=0.
  - wr_en has priority when rd_en and wr_en are both high.
- Word index = (address - MEM_BASE) >> 2, low 17 bits kept; out-of-range addresses wrap modulo 2^17 words.
- LOW:
  - SRAM_ADDR = {idx, 1'b0}; ready = 0.
  - Read: OE_N=0, WE_N=1, DQ hi-Z.
  - Write: OE_N=1, WE_N=0, DQ = wdata[15:0].
  - Counter increments each cycle. When counter == WAIT_CYCLES: read captures DQ into read_data[15:0]; go to HIGH; counter=0.
- HIGH:
  - Same as LOW with SRAM_ADDR = {idx, 1'b1} and DQ = wdata[31:16].
  - On the last cycle, read captures DQ into read_data[31:16]; go to DONE.
- DONE:
  - ready = 1; WE_N=1; OE_N=1; DQ hi-Z.
  - Next state is IDLE unconditionally, so the same request still asserted in DONE is not re-issued.
- Latency:
  - ready low for 1 + 2*(WAIT_CYCLES+1) cycles from the first cycle the request is seen in IDLE, then high in DONE.
  - Default: 5 cycles low, 6th cycle high.
- read_data holds its value until the next read overwrites it; writes never change read_data.
- Request inputs are ignored outside IDLE:
  - Changes or deassertion mid-transaction do not alter the latched op, address or data.
  - The transaction always completes.
- Back-to-back requests: a request present in the cycle after DONE (back in IDLE) starts a new transaction; there is one idle cycle minimum between transactions.
- WE_N must never be low in two different address phases without the address changing on the same edge; WE_N deasserts in DONE.
- No request (rd_en=wr_en=0): remain in IDLE, ready=1, SRAM idle.

Test Plan:
- Reset mid-op: assert store, drop rst in HIGH phase.
  - Required: WE_N=1, DQ hi-Z, state IDLE immediately.
  - Required: on reset release with no request, ready=1.
- Store, WAIT_CYCLES=1: wr_en, address=1024, data=0xDEADBEEF.
  - Required: ready low 5 cycles.
  - Required: SRAM_ADDR=0 with DQ=0xBEEF and WE_N=0 for 2 cycles, then SRAM_ADDR=1 with DQ=0xDEAD for 2 cycles.
  - Required: ready=1 on 6th cycle.
- Load back: rd_en, address=1024 on SRAM model.
  - Required: OE_N=0 for 4 cycles, WE_N=1 throughout.
  - Required: read_data=0xDEADBEEF in DONE and held through a following store.
- Address mapping: store to address=1032.
  - Required: SRAM_ADDR=4 then 5.
- Address wrap: store to address=1020.
  - Required: word index 0x1FFFF, SRAM_ADDR=0x3FFFE then 0x3FFFF.
- Simultaneous and unstable requests: rd_en=wr_en=1 at address 1028, data=0x12345678; toggle address and rd_en mid-transaction.
  - Required: a write is performed to SRAM_ADDR 2/3 with the latched data.
  - Required: exactly one transaction, and no re-issue in DONE.

Source files
------------

// File: rtl/sram_access_controller.sv
// SRAM access controller: splits each 32-bit MEM-stage load/store into two
// 16-bit SRAM accesses (low half, then high half). Each half-access is held
// for WAIT_CYCLES+1 cycles, and ready stays low while a transaction runs.
module sram_access_controller #(
    parameter int MEM_BASE    = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT   = CW'(WAIT_CYCLES);
    localparam logic [31:0]   MEM_BASE_W = 32'(MEM_BASE);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          isWrite_q, isWrite_d;
    logic [16:0]   idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   readData_q, readData_d;
    logic          dqOe;
    logic [15:0]   dqOut;
    logic [16:0]   reqIdx;

    // Word index relative to MEM_BASE; the 17-bit truncation makes
    // out-of-range addresses wrap around the SRAM.
    assign reqIdx = 17'((address - MEM_BASE_W) >> 2);

    assign SRAM_DQ   = dqOe ? dqOut : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign read_data = readData_q;

    // State, counter, latched request and load result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            isWrite_q  <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            readData_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            isWrite_q  <= isWrite_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            readData_q <= readData_d;
        end
    end

    // Next-state logic and SRAM strobes; strobes depend only on the state,
    // so an asynchronous reset releases the bus immediately.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        isWrite_d  = isWrite_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        readData_d = readData_q;
        ready      = 1'b1;
        SRAM_ADDR  = '0;
        SRAM_WE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        dqOe       = 1'b0;
        dqOut      = '0;
        case (state_q)
            IDLE: begin
                ready = ~(rd_en | wr_en);
                if (rd_en | wr_en) begin
                    isWrite_d = wr_en;
                    idx_d     = reqIdx;
                    wdata_d   = write_data;
                    cnt_d     = '0;
                    state_d   = LOW;
                end
            end
            LOW: begin
                ready     = 1'b0;
                SRAM_ADDR = {idx_q, 1'b0};
                if (isWrite_q) begin
                    SRAM_WE_N = 1'b0;
                    dqOe      = 1'b1;
                    dqOut     = wdata_q[15:0];
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                    if (!isWrite_q) begin
                        readData_d[15:0] = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HIGH: begin
                ready     = 1'b0;
                SRAM_ADDR = {idx_q, 1'b1};
                if (isWrite_q) begin
                    SRAM_WE_N = 1'b0;
                    dqOe      = 1'b1;
                    dqOut     = wdata_q[31:16];
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!isWrite_q) begin
                        readData_d[31:16] = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_access_controller.sv
// Directed testbench for sram_access_controller with a behavioural SRAM.
module tb_sram_access_controller;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sramDq;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic        SRAM_CE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    logic [15:0] mem [0:262143];
    int          writeCount7 = 0;
    int          checks = 0;
    int          errors = 0;

    sram_access_controller #(.MEM_BASE(1024), .WAIT_CYCLES(1)) dut (
        .clk(clk),
        .rst(rst),
        .rd_en(rd_en),
        .wr_en(wr_en),
        .address(address),
        .write_data(write_data),
        .read_data(read_data),
        .ready(ready),
        .SRAM_DQ(sramDq),
        .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N),
        .SRAM_OE_N(SRAM_OE_N),
        .SRAM_CE_N(SRAM_CE_N),
        .SRAM_UB_N(SRAM_UB_N),
        .SRAM_LB_N(SRAM_LB_N)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM read path: the chip drives the bus while output-enabled and not writing.
    assign sramDq = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'bz;

    // SRAM write path, also counting every write that lands on halfword 7.
    always @(posedge clk) begin
        if (!SRAM_WE_N) begin
            mem[SRAM_ADDR] <= sramDq;
            if (SRAM_ADDR == 18'd7) writeCount7 <= writeCount7 + 1;
        end
    end

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data);
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkPhase(input string tag, input logic expReady,
                              input logic [17:0] expAddr, input logic expWe,
                              input logic expOe, input logic [15:0] expDq,
                              input logic checkDq);
        checkOutput({tag, "_ready"}, {31'd0, ready}, {31'd0, expReady});
        checkOutput({tag, "_addr"}, {14'd0, SRAM_ADDR}, {14'd0, expAddr});
        checkOutput({tag, "_we"}, {31'd0, SRAM_WE_N}, {31'd0, expWe});
        checkOutput({tag, "_oe"}, {31'd0, SRAM_OE_N}, {31'd0, expOe});
        if (checkDq) checkOutput({tag, "_dq"}, {16'd0, sramDq}, {16'd0, expDq});
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        checkPhase("rst", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);
        checkOutput("rst_rdata", read_data, 32'h0);
        checkOutput("rst_ties", {29'd0, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkPhase("idle0", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);

        // Store 0xDEADBEEF to 1024 -> halfwords 0 and 1
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        #1 checkOutput("st_req_ready", {31'd0, ready}, 32'd0);
        @(negedge clk); checkPhase("st_low0", 1'b0, 18'd0, 1'b0, 1'b1, 16'hBEEF, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk); checkPhase("st_low1", 1'b0, 18'd0, 1'b0, 1'b1, 16'hBEEF, 1'b1);
        @(negedge clk); checkPhase("st_high0", 1'b0, 18'd1, 1'b0, 1'b1, 16'hDEAD, 1'b1);
        @(negedge clk); checkPhase("st_high1", 1'b0, 18'd1, 1'b0, 1'b1, 16'hDEAD, 1'b1);
        @(negedge clk); checkPhase("st_done", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);
        @(negedge clk); checkPhase("st_idle", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);

        // Load back from 1024
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'd0);
        #1 checkOutput("ld_req_ready", {31'd0, ready}, 32'd0);
        @(negedge clk); checkPhase("ld_low0", 1'b0, 18'd0, 1'b1, 1'b0, 16'hBEEF, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk); checkPhase("ld_low1", 1'b0, 18'd0, 1'b1, 1'b0, 16'hBEEF, 1'b1);
        @(negedge clk); checkPhase("ld_high0", 1'b0, 18'd1, 1'b1, 1'b0, 16'hDEAD, 1'b1);
        @(negedge clk); checkPhase("ld_high1", 1'b0, 18'd1, 1'b1, 1'b0, 16'hDEAD, 1'b1);
        @(negedge clk); checkPhase("ld_done", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);
        checkOutput("ld_rdata", read_data, 32'hDEADBEEF);
        @(negedge clk);

        // Store to 1032 -> halfwords 4 and 5; read_data must hold
        applyStimulus(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D);
        @(negedge clk); checkPhase("map_low0", 1'b0, 18'd4, 1'b0, 1'b1, 16'hF00D, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk); checkPhase("map_low1", 1'b0, 18'd4, 1'b0, 1'b1, 16'hF00D, 1'b1);
        @(negedge clk); checkPhase("map_high0", 1'b0, 18'd5, 1'b0, 1'b1, 16'hCAFE, 1'b1);
        @(negedge clk); checkPhase("map_high1", 1'b0, 18'd5, 1'b0, 1'b1, 16'hCAFE, 1'b1);
        @(negedge clk); checkPhase("map_done", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);
        checkOutput("map_rdata_held", read_data, 32'hDEADBEEF);
        @(negedge clk);

        // Store to 1020 wraps to word 0x1FFFF
        applyStimulus(1'b0, 1'b1, 32'd1020, 32'h0BADC0DE);
        @(negedge clk); checkPhase("wrap_low0", 1'b0, 18'h3FFFE, 1'b0, 1'b1, 16'hC0DE, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk); checkPhase("wrap_low1", 1'b0, 18'h3FFFE, 1'b0, 1'b1, 16'hC0DE, 1'b1);
        @(negedge clk); checkPhase("wrap_high0", 1'b0, 18'h3FFFF, 1'b0, 1'b1, 16'h0BAD, 1'b1);
        @(negedge clk); checkPhase("wrap_high1", 1'b0, 18'h3FFFF, 1'b0, 1'b1, 16'h0BAD, 1'b1);
        @(negedge clk); checkPhase("wrap_done", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);
        @(negedge clk);

        // Simultaneous rd/wr at 1028, with unstable inputs mid-transaction
        applyStimulus(1'b1, 1'b1, 32'd1028, 32'h12345678);
        @(negedge clk); checkPhase("sim_low0", 1'b0, 18'd2, 1'b0, 1'b1, 16'h5678, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'd2000, 32'hFFFFFFFF);
        @(negedge clk); checkPhase("sim_low1", 1'b0, 18'd2, 1'b0, 1'b1, 16'h5678, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'd4000, 32'h00000000);
        @(negedge clk); checkPhase("sim_high0", 1'b0, 18'd3, 1'b0, 1'b1, 16'h1234, 1'b1);
        @(negedge clk); checkPhase("sim_high1", 1'b0, 18'd3, 1'b0, 1'b1, 16'h1234, 1'b1);
        @(negedge clk); checkPhase("sim_done", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk); checkPhase("sim_idle0", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);
        @(negedge clk); checkPhase("sim_idle1", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);
        checkOutput("sim_rdata_held", read_data, 32'hDEADBEEF);

        // Load back from 1028 confirms the latched write data landed
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); checkPhase("ld2_done", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);
        checkOutput("ld2_rdata", read_data, 32'h12345678);
        @(negedge clk);

        // Store to 1036, reset asserted during the high phase
        applyStimulus(1'b0, 1'b1, 32'd1036, 32'hAAAA5555);
        @(negedge clk); checkPhase("rm_low0", 1'b0, 18'd6, 1'b0, 1'b1, 16'h5555, 1'b1);
        @(negedge clk);
        @(negedge clk); checkPhase("rm_high0", 1'b0, 18'd7, 1'b0, 1'b1, 16'hAAAA, 1'b1);
        rst = 1'b0;
        #1 checkPhase("rm_reset", 1'b0, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);
        checkOutput("rm_rdata", read_data, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        #1 checkOutput("rm_ready_noreq", {31'd0, ready}, 32'd1);
        @(negedge clk);
        checkOutput("rm_no_high_write", writeCount7, 32'd0);
        rst = 1'b1;
        @(negedge clk); checkPhase("rm_release", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);
        @(negedge clk); checkPhase("rm_idle", 1'b1, 18'd0, 1'b1, 1'b1, 16'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
